// File: rtl/cpu_core_ws_pkg.sv
// Opcode values, FSM state codes and decode helpers shared by the cpu_core_ws core.
package cpu_core_ws_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_LOADLO = 4'h6;
  localparam logic [3:0] OP_LOADHI = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'h9;
  localparam logic [3:0] OP_IN     = 4'hA;
  localparam logic [3:0] OP_OUT    = 4'hB;
  localparam logic [3:0] OP_JMP    = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_EXEC      = 4'd3;
  localparam logic [3:0] ST_MEMWAIT   = 4'd4;
  localparam logic [3:0] ST_WRITEBACK = 4'd5;
  localparam logic [3:0] ST_NEXT      = 4'd6;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] reg1;
    logic [3:0] reg2;
    logic [3:0] reg3;
  } instr_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_IN) || (op == OP_OUT);
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LOADLO) || (op == OP_LOADHI) ||
           (op == OP_LOAD) || (op == OP_IN);
  endfunction

endpackage

// File: rtl/reg_file_ws.sv
// NUM_REGS x WORD_SIZE register file: two async read ports, one sync write port, sync clear.
module reg_file_ws #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [3:0]           waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [3:0]           raddr_a,
  input  logic [3:0]           raddr_b,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic [WORD_SIZE-1:0] rdata_b
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [WORD_SIZE-1:0] regs [NUM_REGS];

  // Indices at or above NUM_REGS are unimplemented: they read 0 and swallow writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (32'(waddr) < NUM_REGS)) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata_a = (32'(raddr_a) < NUM_REGS) ? regs[raddr_a[AW-1:0]] : '0;
  assign rdata_b = (32'(raddr_b) < NUM_REGS) ? regs[raddr_b[AW-1:0]] : '0;

endmodule

// File: rtl/cpu_core_ws.sv
// Multi-cycle 16-bit-ISA core; every instruction, data and port access waits on a ready handshake.
//  state     | meaning
//  IDLE      | parked, waiting for run
//  FETCH     | ins_read_enable high until ins_ready, latch instruction
//  DECODE    | latch register operands
//  EXEC      | compute ALU/LOADLO/LOADHI result, set up memory/port address and data
//  MEMWAIT   | one request high until its ready
//  WRITEBACK | write R[reg1] when the opcode produces a result
//  NEXT      | advance or branch IP, then FETCH or IDLE depending on run
module cpu_core_ws
  import cpu_core_ws_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int NUM_REGS      = 16,
  parameter int INS_ADDR_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  output logic [INS_ADDR_SIZE-1:0] ins_pointer,
  output logic                     ins_read_enable,
  input  logic                     ins_ready,
  input  logic [15:0]              ins_mem,
  output logic [WORD_SIZE-1:0]     mem_addr,
  output logic [WORD_SIZE-1:0]     mem_wdata,
  output logic                     mem_get,
  output logic                     mem_set,
  input  logic                     mem_ready,
  input  logic [WORD_SIZE-1:0]     mem_rdata,
  output logic [WORD_SIZE-1:0]     port_addr,
  output logic [WORD_SIZE-1:0]     port_write_data,
  output logic                     port_read,
  output logic                     port_write,
  input  logic                     port_ready,
  input  logic [WORD_SIZE-1:0]     port_read_data,
  output logic [3:0]               state,
  output logic [3:0]               opcode
);
  instr_t                   instr;
  logic [3:0]               fsm_state;
  logic [INS_ADDR_SIZE-1:0] ip;
  logic [WORD_SIZE-1:0]     opa, opb, result, exec_result, rdata_a, rdata_b;
  logic [7:0]               bigval;
  logic [3:0]               rd_b_sel;
  logic                     branch_taken, access_ready, is_data_bus;

  assign bigval       = {instr.reg2, instr.reg3};
  // Second read port serves R[reg3] for ALU ops and R[reg1] for store/out data, BR and LOADLO/HI.
  assign rd_b_sel     = is_alu_op(instr.op) ? instr.reg3 : instr.reg1;
  assign branch_taken = (instr.op == OP_JMP) || ((instr.op == OP_BR) && (opb != '0));
  assign is_data_bus  = (instr.op == OP_LOAD) || (instr.op == OP_STORE);
  assign access_ready = is_data_bus ? mem_ready : port_ready;

  reg_file_ws #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      ((fsm_state == ST_WRITEBACK) && writes_reg(instr.op)),
    .waddr   (instr.reg1),
    .wdata   (result),
    .raddr_a (instr.reg2),
    .raddr_b (rd_b_sel),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_comb begin
    exec_result = opb;
    case (instr.op)
      OP_ADD:    exec_result = opa + opb;
      OP_SUB:    exec_result = opa - opb;
      OP_AND:    exec_result = opa & opb;
      OP_OR:     exec_result = opa | opb;
      OP_XOR:    exec_result = opa ^ opb;
      OP_LOADLO: exec_result[7:0] = bigval;
      OP_LOADHI: exec_result[15:8] = bigval;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state       <= ST_IDLE;
      ip              <= '0;
      instr           <= '0;
      opa             <= '0;
      opb             <= '0;
      result          <= '0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      port_addr       <= '0;
      port_write_data <= '0;
    end else begin
      case (fsm_state)
        ST_IDLE: if (run) fsm_state <= ST_FETCH;
        ST_FETCH: begin
          if (ins_ready) begin
            instr     <= ins_mem;
            fsm_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          opa       <= rdata_a;
          opb       <= rdata_b;
          fsm_state <= ST_EXEC;
        end
        ST_EXEC: begin
          result <= exec_result;
          if (is_data_bus) begin
            mem_addr  <= opa + WORD_SIZE'(instr.reg3);
            mem_wdata <= opb;
          end else if (is_mem_op(instr.op)) begin
            port_addr       <= opa + WORD_SIZE'(instr.reg3);
            port_write_data <= opb;
          end
          fsm_state <= is_mem_op(instr.op) ? ST_MEMWAIT : ST_WRITEBACK;
        end
        ST_MEMWAIT: begin
          if (access_ready) begin
            if (instr.op == OP_LOAD)    result <= mem_rdata;
            else if (instr.op == OP_IN) result <= port_read_data;
            fsm_state <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: fsm_state <= ST_NEXT;
        ST_NEXT: begin
          ip        <= branch_taken ? ip + INS_ADDR_SIZE'($signed(bigval))
                                    : ip + INS_ADDR_SIZE'(1);
          fsm_state <= run ? ST_FETCH : ST_IDLE;
        end
        default: fsm_state <= ST_IDLE;
      endcase
    end
  end

  assign ins_pointer     = ip;
  assign ins_read_enable = (fsm_state == ST_FETCH);
  assign mem_get         = (fsm_state == ST_MEMWAIT) && (instr.op == OP_LOAD);
  assign mem_set         = (fsm_state == ST_MEMWAIT) && (instr.op == OP_STORE);
  assign port_read       = (fsm_state == ST_MEMWAIT) && (instr.op == OP_IN);
  assign port_write      = (fsm_state == ST_MEMWAIT) && (instr.op == OP_OUT);
  assign state           = fsm_state;
  assign opcode          = instr.op;

endmodule

// File: tb/tb_cpu_core_ws.sv
// Bench for cpu_core_ws: wait-state responders, an ISA-level reference model and directed scenarios.
module tb_cpu_core_ws;
  import cpu_core_ws_pkg::*;

  typedef struct {
    int          kind;  // 0 store, 1 out, 2 load, 3 in
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset, run, run32;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]  ins_pointer;
  logic        ins_read_enable, ins_ready, mem_get, mem_set, mem_ready;
  logic        port_read, port_write, port_ready;
  logic [15:0] ins_mem, mem_addr, mem_wdata, mem_rdata, port_addr, port_write_data, port_read_data;
  logic [3:0]  state, opcode;

  logic [7:0]  ins_pointer32;
  logic        ins_read_enable32, ins_ready32, mem_get32, mem_set32, mem_ready32;
  logic        port_read32, port_write32, port_ready32;
  logic [15:0] ins_mem32;
  logic [31:0] mem_addr32, mem_wdata32, mem_rdata32, port_addr32, port_write_data32, port_read_data32;
  logic [3:0]  state32, opcode32;

  cpu_core_ws dut (
    .clk(clk), .reset(reset), .run(run), .ins_pointer(ins_pointer),
    .ins_read_enable(ins_read_enable), .ins_ready(ins_ready), .ins_mem(ins_mem),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_get(mem_get), .mem_set(mem_set),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .port_addr(port_addr),
    .port_write_data(port_write_data), .port_read(port_read), .port_write(port_write),
    .port_ready(port_ready), .port_read_data(port_read_data), .state(state), .opcode(opcode)
  );

  cpu_core_ws #(.WORD_SIZE(32)) dut32 (
    .clk(clk), .reset(reset), .run(run32), .ins_pointer(ins_pointer32),
    .ins_read_enable(ins_read_enable32), .ins_ready(ins_ready32), .ins_mem(ins_mem32),
    .mem_addr(mem_addr32), .mem_wdata(mem_wdata32), .mem_get(mem_get32), .mem_set(mem_set32),
    .mem_ready(mem_ready32), .mem_rdata(mem_rdata32), .port_addr(port_addr32),
    .port_write_data(port_write_data32), .port_read(port_read32), .port_write(port_write32),
    .port_ready(port_ready32), .port_read_data(port_read_data32), .state(state32),
    .opcode(opcode32)
  );

  int vectors = 0, miscompares = 0;
  logic [15:0] rom [256];
  logic [15:0] rom32 [8];
  ev_t  log_q[$], exp_q[$];
  logic [7:0] fetch_a[$];
  int   fetch_c[$];
  bit   rand_wait = 1'b0;
  int   iw_cfg = 0, mw_cfg = 0, pw_cfg = 0;
  int   icnt = 0, mcnt = 0, pcnt = 0, iwait = 0, mwait = 0, pwait = 0;
  logic [15:0] mr [16];
  bit   got32;
  logic [31:0] st32_addr, st32_data;

  function automatic logic [15:0] load_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] in_val(input logic [15:0] a);
    return ~a + 16'h0007;
  endfunction

  function automatic int next_wait(input int cfg);
    return rand_wait ? int'($urandom_range(0, 3)) : cfg;
  endfunction

  // Slow instruction ROM, data RAM and port responders; ready while idle is random junk.
  initial begin
    ins_ready = 1'b0; ins_mem = '0; mem_ready = 1'b0; mem_rdata = '0;
    port_ready = 1'b0; port_read_data = '0;
    forever begin
      @(negedge clk);
      if (ins_read_enable) begin
        if (icnt >= iwait) begin
          ins_ready = 1'b1; ins_mem = rom[ins_pointer];
          fetch_a.push_back(ins_pointer); fetch_c.push_back(cyc);
          icnt = 0; iwait = next_wait(iw_cfg);
        end else begin
          ins_ready = 1'b0; ins_mem = 16'($urandom); icnt++;
        end
      end else begin
        icnt = 0; ins_ready = 1'($urandom_range(0, 1)); ins_mem = 16'($urandom);
      end
      if (mem_get || mem_set) begin
        if (mcnt >= mwait) begin
          mem_ready = 1'b1;
          if (mem_get) begin
            mem_rdata = load_val(mem_addr); log_q.push_back('{2, mem_addr, 16'h0});
          end else begin
            mem_rdata = 16'($urandom); log_q.push_back('{0, mem_addr, mem_wdata});
          end
          mcnt = 0; mwait = next_wait(mw_cfg);
        end else begin
          mem_ready = 1'b0; mem_rdata = 16'($urandom); mcnt++;
        end
      end else begin
        mcnt = 0; mem_ready = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
      end
      if (port_read || port_write) begin
        if (pcnt >= pwait) begin
          port_ready = 1'b1;
          if (port_read) begin
            port_read_data = in_val(port_addr); log_q.push_back('{3, port_addr, 16'h0});
          end else begin
            port_read_data = 16'($urandom); log_q.push_back('{1, port_addr, port_write_data});
          end
          pcnt = 0; pwait = next_wait(pw_cfg);
        end else begin
          port_ready = 1'b0; port_read_data = 16'($urandom); pcnt++;
        end
      end else begin
        pcnt = 0; port_ready = 1'($urandom_range(0, 1)); port_read_data = 16'($urandom);
      end
    end
  end

  // Zero-wait environment for the 32-bit instance.
  initial begin
    ins_ready32 = 1'b1; mem_ready32 = 1'b1; port_ready32 = 1'b1;
    mem_rdata32 = 32'hAAAA_0000; port_read_data32 = '0; ins_mem32 = '0;
    forever begin
      @(negedge clk);
      ins_mem32 = rom32[ins_pointer32[2:0]];
      if (mem_set32 && !got32) begin
        got32 = 1'b1; st32_addr = mem_addr32; st32_data = mem_wdata32;
      end
    end
  end

  // ISA-level interpreter for straight-line code; records the bus traffic it expects.
  task automatic model_exec(input logic [15:0] ins);
    logic [3:0]  op, r1, r2, r3;
    logic [15:0] ad;
    op = ins[15:12]; r1 = ins[11:8]; r2 = ins[7:4]; r3 = ins[3:0];
    ad = mr[r2] + {12'h0, r3};
    case (op)
      4'h0: mr[r1] = mr[r2] + mr[r3];
      4'h1: mr[r1] = mr[r2] - mr[r3];
      4'h2: mr[r1] = mr[r2] & mr[r3];
      4'h3: mr[r1] = mr[r2] | mr[r3];
      4'h4: mr[r1] = mr[r2] ^ mr[r3];
      4'h6: mr[r1][7:0] = ins[7:0];
      4'h7: mr[r1][15:8] = ins[7:0];
      4'h8: begin exp_q.push_back('{2, ad, 16'h0}); mr[r1] = load_val(ad); end
      4'h9: exp_q.push_back('{0, ad, mr[r1]});
      4'hA: begin exp_q.push_back('{3, ad, 16'h0}); mr[r1] = in_val(ad); end
      4'hB: exp_q.push_back('{1, ad, mr[r1]});
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; run32 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    log_q.delete(); fetch_a.delete(); fetch_c.delete();
    icnt = 0; mcnt = 0; pcnt = 0;
    iwait = next_wait(iw_cfg); mwait = next_wait(mw_cfg); pwait = next_wait(pw_cfg);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) rom[i] = 16'hE000;
  endtask

  task automatic wait_log(input int n, input string name);
    for (int t = 0; t < 5000 && log_q.size() < n; t++) @(negedge clk);
    vectors++;
    if (log_q.size() < n) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d bus events, need %0d", name, log_q.size(), n);
    end
  endtask

  task automatic check_ev(input int idx, input ev_t e, input string name);
    vectors++;
    if (idx >= log_q.size()) begin
      miscompares++;
      $display("FAIL %s[%0d]: event missing, expected kind %0d addr %h data %h",
               name, idx, e.kind, e.addr, e.data);
    end else if (log_q[idx].kind !== e.kind || log_q[idx].addr !== e.addr ||
                 log_q[idx].data !== e.data) begin
      miscompares++;
      $display("FAIL %s[%0d]: got kind %0d addr %h data %h, expected kind %0d addr %h data %h",
               name, idx, log_q[idx].kind, log_q[idx].addr, log_q[idx].data,
               e.kind, e.addr, e.data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; run32 = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (state !== ST_IDLE || state32 !== ST_IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d/%0d, expected 0", state, state32);
    end
    if (ins_pointer !== 8'h00 || opcode !== 4'h0) begin
      miscompares++; $display("FAIL reset_ip: got ip %h opcode %h, expected 0", ins_pointer, opcode);
    end
    if ({ins_read_enable, mem_get, mem_set, port_read, port_write} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_req: got %b, expected 00000",
               {ins_read_enable, mem_get, mem_set, port_read, port_write});
    end
    if ({mem_addr, mem_wdata, port_addr, port_write_data} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h %h %h %h, expected all 0",
               mem_addr, mem_wdata, port_addr, port_write_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu_latency();
    rand_wait = 1'b0; iw_cfg = 0; mw_cfg = 0; pw_cfg = 0;
    fill_nop();
    rom[0] = 16'h61FF; rom[1] = 16'h71FF; rom[2] = 16'h6202; rom[3] = 16'h0312;
    rom[4] = 16'h9300; rom[5] = 16'h6634; rom[6] = 16'h7612; rom[7] = 16'h9601;
    do_reset();
    run = 1'b1;
    wait_log(2, "alu_log");
    check_ev(0, '{0, 16'h0000, 16'h0001}, "add_wrap");
    check_ev(1, '{0, 16'h0001, 16'h1234}, "loadlo_hi");
    vectors += 2;
    if (fetch_c.size() < 6 || fetch_c[4] - fetch_c[3] != 5) begin
      miscompares++;
      $display("FAIL alu_latency: got %0d cycles, expected 5",
               fetch_c.size() >= 5 ? fetch_c[4] - fetch_c[3] : -1);
    end
    if (fetch_c.size() < 6 || fetch_c[5] - fetch_c[4] != 6) begin
      miscompares++;
      $display("FAIL mem_latency: got %0d cycles, expected 6",
               fetch_c.size() >= 6 ? fetch_c[5] - fetch_c[4] : -1);
    end
    run = 1'b0;
  endtask

  task automatic test_load_wait();
    int get_cycles = 0, bad_addr = 0;
    rand_wait = 1'b0; iw_cfg = 1; mw_cfg = 4; pw_cfg = 0;
    fill_nop();
    rom[0] = 16'h6210; rom[1] = 16'h8423; rom[2] = 16'h9400;
    do_reset();
    run = 1'b1;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (mem_get) begin
        get_cycles++;
        if (mem_addr !== 16'h0013) bad_addr++;
      end
    end
    run = 1'b0;
    vectors += 2;
    if (get_cycles != 5) begin
      miscompares++; $display("FAIL load_hold: got %0d request cycles, expected 5", get_cycles);
    end
    if (bad_addr != 0) begin
      miscompares++; $display("FAIL load_addr_stable: got %0d bad cycles, expected 0", bad_addr);
    end
    check_ev(0, '{2, 16'h0013, 16'h0000}, "load_req");
    check_ev(1, '{0, 16'h0000, load_val(16'h0013)}, "load_data");
  endtask

  task automatic test_branch();
    logic [7:0] exp_ip [8];
    exp_ip = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h10, 8'h0E, 8'hFE, 8'h03};
    rand_wait = 1'b1;
    fill_nop();
    rom[8'h00] = 16'hC010; rom[8'h10] = 16'hD5FE; rom[8'h11] = 16'h6501;
    rom[8'h12] = 16'hC0FE; rom[8'h0E] = 16'hC0F0; rom[8'hFE] = 16'hC005;
    do_reset();
    run = 1'b1;
    for (int t = 0; t < 2000 && fetch_a.size() < 8; t++) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (i >= fetch_a.size() || fetch_a[i] !== exp_ip[i]) begin
        miscompares++;
        $display("FAIL branch_ip[%0d]: got %h, expected %h", i,
                 i < fetch_a.size() ? fetch_a[i] : 8'hxx, exp_ip[i]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    rand_wait = 1'b0; iw_cfg = 0; mw_cfg = 0; pw_cfg = 100000;
    fill_nop();
    rom[0] = 16'h6755; rom[1] = 16'hB702;
    do_reset();
    run = 1'b1;
    for (int t = 0; t < 200 && !port_write; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (port_write !== 1'b1 || port_addr !== 16'h0002 || port_write_data !== 16'h0055) begin
      miscompares++;
      $display("FAIL out_hold: got req %b addr %h data %h, expected 1 0002 0055",
               port_write, port_addr, port_write_data);
    end
    for (int i = 0; i < 16; i++) rom[i] = {4'h9, 4'(i), 4'h0, 4'(i)};
    rom[1] = 16'h9101;
    reset = 1'b1;
    @(negedge clk);
    vectors += 2;
    if (port_write !== 1'b0 || port_addr !== 16'h0 || port_write_data !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_drop: got req %b addr %h data %h, expected 0", port_write,
               port_addr, port_write_data);
    end
    if (state !== ST_IDLE || ins_pointer !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_park: got state %0d ip %h, expected 0 00", state, ins_pointer);
    end
    pw_cfg = 0; pwait = 0;
    reset = 1'b0;
    log_q.delete(); fetch_a.delete(); fetch_c.delete();
    wait_log(16, "regs_cleared");
    for (int i = 0; i < 16; i++) check_ev(i, '{0, 16'(i), 16'h0000}, "reg_zero");
    run = 1'b0;
  endtask

  task automatic test_run_gate();
    rand_wait = 1'b1;
    fill_nop();
    rom[0] = 16'h6101; rom[1] = 16'h6202;
    do_reset();
    run = 1'b1;
    for (int t = 0; t < 200 && fetch_a.size() < 1; t++) @(negedge clk);
    run = 1'b0;
    repeat (20) @(negedge clk);
    vectors += 2;
    if (state !== ST_IDLE || ins_read_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL run_park: got state %0d fetch %b, expected 0 0", state, ins_read_enable);
    end
    if (fetch_a.size() != 1) begin
      miscompares++; $display("FAIL run_no_fetch: got %0d fetches, expected 1", fetch_a.size());
    end
    run = 1'b1;
    for (int t = 0; t < 200 && fetch_a.size() < 2; t++) @(negedge clk);
    run = 1'b0;
    vectors++;
    if (fetch_a.size() < 2 || fetch_a[1] !== 8'h01) begin
      miscompares++;
      $display("FAIL run_resume: got ip %h, expected 01", fetch_a.size() >= 2 ? fetch_a[1] : 8'hxx);
    end
  endtask

  task automatic test_wide32();
    rom32 = '{16'h8100, 16'h6134, 16'h7112, 16'h9104, 16'hC0FC, 16'hE000, 16'hE000, 16'hE000};
    got32 = 1'b0;
    run32 = 1'b1;
    for (int t = 0; t < 300 && !got32; t++) @(negedge clk);
    run32 = 1'b0;
    vectors++;
    if (got32 !== 1'b1 || st32_addr !== 32'h4 || st32_data !== 32'hAAAA_1234) begin
      miscompares++;
      $display("FAIL wide_loadlo_hi: got seen %b addr %h data %h, expected 1 00000004 aaaa1234",
               got32, st32_addr, st32_data);
    end
  endtask

  task automatic test_random(input int iter);
    logic [3:0]  ops [12];
    logic [31:0] rv;
    int          k;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE};
    k = 24;
    rand_wait = 1'b1;
    fill_nop();
    for (int i = 0; i < k; i++) begin
      rv = $urandom;
      rom[i] = {ops[$urandom_range(0, 11)], rv[11:0]};
    end
    for (int i = 0; i < 16; i++) rom[k + i] = {4'h9, 4'(i), 4'h0, 4'(i)};
    for (int i = 0; i < 16; i++) mr[i] = '0;
    exp_q.delete();
    for (int i = 0; i < k + 16; i++) model_exec(rom[i]);
    do_reset();
    run = 1'b1;
    wait_log(exp_q.size(), $sformatf("rand%0d_log", iter));
    run = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) check_ev(i, exp_q[i], $sformatf("rand%0d", iter));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; run32 = 1'b0; got32 = 1'b0;
    st32_addr = '0; st32_data = '0;
    for (int i = 0; i < 8; i++) rom32[i] = 16'hE000;
    fill_nop();
    test_reset();
    test_alu_latency();
    test_load_wait();
    test_branch();
    test_reset_in_wait();
    test_run_gate();
    test_wide32();
    for (int it = 0; it < 4; it++) test_random(it);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
